// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding,
// default geometry and the read-port address slicing helper.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Low bit of read port k's address within the packed rd_addr bus.
  function automatic int rd_addr_base(input int k, input int addr_w);
    return k * addr_w;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port: array mux, zero-register and not-ready masking,
// plus write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 2 ** ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic [ADDR_W-1:0] addr,
`ifdef REGFILE_BYPASS_EN
  input  logic              fwd_we0,
  input  logic [ADDR_W-1:0] fwd_wa0,
  input  logic [DATA_W-1:0] fwd_wd0,
  input  logic              fwd_we1,
  input  logic [ADDR_W-1:0] fwd_wa1,
  input  logic [DATA_W-1:0] fwd_wd1,
`endif
  input  logic              ready,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = mem[addr];
`ifdef REGFILE_BYPASS_EN
    // Port 1 is evaluated last so it overrides port 0 on a shared address.
    if (fwd_we0 && (fwd_wa0 == addr)) data = fwd_wd0;
    if (fwd_we1 && (fwd_wa1 == addr)) data = fwd_wd1;
`endif
    if (!ready || ((ZERO_REG != 0) && (addr == '0))) data = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with two write ports, optional zero
// register and a post-reset clear sequencer. Define REGFILE_BYPASS_EN for forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              clearing, running;
  logic              wr0, wr1;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    if (state_reg == CLEAR) begin
      clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
      if (clr_cnt_reg == '1) state_next = RUN;
    end
  end

  always_comb begin
    clearing = (state_reg == CLEAR);
    running  = (state_reg == RUN);
    ready    = running;
  end

  // Writes to entry 0 are dropped up front so the bypass never sees them either.
  always_comb begin
    wr0 = we0 && running && !((ZERO_REG != 0) && (wa0 == '0));
    wr1 = we1 && running && !((ZERO_REG != 0) && (wa1 == '0));
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_cnt_reg] <= '0;
    end else begin
      if (wr0) mem[wa0] <= wd0;
      if (wr1) mem[wa1] <= wd1;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .mem    (mem),
      .addr   (rd_addr[rd_addr_base(gi, ADDR_W) +: ADDR_W]),
`ifdef REGFILE_BYPASS_EN
      .fwd_we0(wr0),
      .fwd_wa0(wa0),
      .fwd_wd0(wd0),
      .fwd_we1(wr1),
      .fwd_wa1(wa1),
      .fwd_wd1(wd1),
`endif
      .ready  (running),
      .data   (rd_data[gi*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an array-based model
// of the register file rules (clear sequence, collisions, zero register, forwarding).
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        ready;

  logic [31:0] model [32];
  int total = 0;
  int bad   = 0;

  regfile_mp dut (
    .clk    (clk),
    .rst    (rst),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .we0    (we0),
    .wa0    (wa0),
    .wd0    (wd0),
    .we1    (we1),
    .wa1    (wa1),
    .wd1    (wd1),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Value a read of address a should show this cycle, given the pending writes.
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    logic [31:0] v;
    v = model[a];
`ifdef REGFILE_BYPASS_EN
    if (we0 && wa0 == a) v = wd0;
    if (we1 && wa1 == a) v = wd1;
`endif
    if (a == 5'd0) v = 32'd0;
    return v;
  endfunction

  // Entered at posedge+1; applies one RUN cycle, checks reads, commits writes.
  task automatic do_cycle(input string tag,
                          input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] r0, input logic [4:0] r1);
    we0 = e0; wa0 = a0; wd0 = d0;
    we1 = e1; wa1 = a1; wd1 = d1;
    rd_addr = {r1, r0};
    #3;
    check({tag, "_rd0"}, rd_data[31:0],  expect_rd(r0));
    check({tag, "_rd1"}, rd_data[63:32], expect_rd(r1));
    @(posedge clk);
    if (e0 && a0 != 5'd0) model[a0] = d0;
    if (e1 && a1 != 5'd0) model[a1] = d1;
    #1;
    we0 = 1'b0;
    we1 = 1'b0;
  endtask

  // Called just after rst falls; write attempts during clear must be ignored.
  task automatic wait_clear(input string tag);
    logic [4:0] ra;
    for (int i = 1; i <= 32; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = $urandom;
      we1 = 1'b1; wa1 = 5'(i + 7); wd1 = $urandom;
      @(posedge clk);
      #1;
      check($sformatf("%s_ready_e%0d", tag, i), {31'd0, ready}, (i == 32) ? 32'd1 : 32'd0);
      if (i < 32) begin
        ra = 5'($urandom_range(1, 31));
        rd_addr = {5'd0, ra};
        #1;
        check($sformatf("%s_clrrd_e%0d", tag, i), rd_data[31:0], 32'd0);
      end
    end
    we0 = 1'b0;
    we1 = 1'b0;
    for (int j = 0; j < 32; j++) model[j] = 32'd0;
  endtask

  initial begin
    logic [4:0] a0, a1, r0, r1;
    rst = 1'b1;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    rd_addr = {5'd4, 5'd3};
    #2;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rd",    rd_data[31:0],  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_clear("clr1");

    do_cycle("wr5",   1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 5'd5, 5'd6);
    do_cycle("rd5",   0, 5'd0, 32'd0,        0, 5'd0, 32'd0, 5'd5, 5'd6);
    do_cycle("coll",  1, 5'd9, 32'h11,       1, 5'd9, 32'h22, 5'd9, 5'd5);
    do_cycle("rd9",   0, 5'd0, 32'd0,        0, 5'd0, 32'd0, 5'd9, 5'd9);
    do_cycle("zwr",   1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    do_cycle("zrd",   0, 5'd0, 32'd0,        0, 5'd0, 32'd0, 5'd0, 5'd9);
    do_cycle("byp",   0, 5'd0, 32'd0,        1, 5'd3, 32'hABCD, 5'd3, 5'd1);
    do_cycle("rd3",   0, 5'd0, 32'd0,        0, 5'd0, 32'd0, 5'd3, 5'd3);
    do_cycle("byp01", 1, 5'd12, 32'h1234,    1, 5'd12, 32'h5678, 5'd12, 5'd12);

    for (int n = 0; n < 150; n++) begin
      a0 = 5'($urandom_range(0, 7));
      a1 = 5'($urandom_range(0, 7));
      r0 = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 31));
      do_cycle($sformatf("rnd%0d", n),
               1'($urandom_range(0, 1)), a0, $urandom,
               1'($urandom_range(0, 1)), a1, $urandom, r0, r1);
    end

    do_cycle("wr7", 1, 5'd7, 32'h55, 0, 5'd0, 32'd0, 5'd7, 5'd2);
    rst = 1'b1;
    rd_addr = {5'd2, 5'd7};
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_rd7",   rd_data[31:0],  32'd0);
    #4;
    rst = 1'b0;
    wait_clear("clr2");
    do_cycle("post_rd7", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
